// File: rtl/count_share_arbiter_pkg.sv
// Shared definitions for the two-requester count-sharing arbiter.
`ifndef COUNT_SHARE_ARBITER_PKG_SV
`define COUNT_SHARE_ARBITER_PKG_SV

// Elaboration-time legality check for the completion target (1..2^w-1).
`define CSA_CHECK_TARGET(tgt, w) \
  if (((tgt) < 1) || ((tgt) > ((2 ** (w)) - 1))) begin : g_bad_target \
    $error("count_share_arbiter: TARGET must lie in 1..2^CNT_W-1"); \
  end

package count_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    COUNT = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned IDX_W   = 1;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic [NUM_REQ-1:0] onehot(input idx_t i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

endpackage

`endif

// File: rtl/count_share_arbiter_count.sv
// Shared saturating-at-target up-counter with synchronous clear and terminal flag.
module count_unit #(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned TARGET = 15
) (
  input  logic             CLK,
  input  logic             CLEAR,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  localparam logic [CNT_W-1:0] TGT    = CNT_W'(TARGET);
  localparam logic [CNT_W-1:0] TGT_M1 = CNT_W'(TARGET - 1);

  // Counter register: cleared on request, never advances past TARGET.
  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TGT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign term = (count == TGT_M1);

endmodule

// File: rtl/count_share_arbiter.sv
// Round-robin arbiter sequencing one shared pulse counter between two requesters.
module count_share_arbiter
  import count_share_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned TARGET = 15
) (
  input  logic               CLK,
  input  logic               CLEAR,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] X,
  output logic [NUM_REQ-1:0] GNT,
  output logic [NUM_REQ-1:0] DONE,
  output logic               BUSY,
  output logic [CNT_W-1:0]   CNT_OUT
);

  `CSA_CHECK_TARGET(TARGET, CNT_W)

  state_t state, state_next;
  idx_t   winner, winner_next;
  idx_t   last, last_next;
  logic   cnt_clr, cnt_en, cnt_term;
  logic [CNT_W-1:0] count;

  count_unit #(
    .CNT_W (CNT_W),
    .TARGET(TARGET)
  ) u_count (
    .CLK  (CLK),
    .CLEAR(CLEAR),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(count),
    .term (cnt_term)
  );

  // State, latched winner and round-robin pointer.
  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      state  <= IDLE;
      winner <= '0;
      last   <= idx_t'(1);
    end else begin
      state  <= state_next;
      winner <= winner_next;
      last   <= last_next;
    end
  end

  // Arbitration and job sequencing; abort takes precedence over the final increment.
  always_comb begin
    state_next  = state;
    winner_next = winner;
    last_next   = last;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      IDLE: begin
        if (|REQ) begin
          state_next = CLR;
          if (&REQ) winner_next = ~last;
          else      winner_next = REQ[1] ? idx_t'(1) : idx_t'(0);
        end
      end
      CLR: begin
        cnt_clr = 1'b1;
        if (REQ[winner]) begin
          state_next = COUNT;
        end else begin
          state_next = IDLE;
          last_next  = winner;
        end
      end
      COUNT: begin
        if (!REQ[winner]) begin
          state_next = IDLE;
          last_next  = winner;
        end else if (X[winner]) begin
          cnt_en = 1'b1;
          if (cnt_term) state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
        last_next  = winner;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    GNT     = (state != IDLE) ? onehot(winner) : '0;
    DONE    = (state == FIN)  ? onehot(winner) : '0;
    BUSY    = (state != IDLE);
    CNT_OUT = count;
  end

endmodule

// File: tb/tb_count_share_arbiter.sv
module tb_count_share_arbiter;

  typedef struct {
    logic [1:0] done;
    logic [3:0] cnt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       CLEAR;
  logic [1:0] REQ, X, GNT, DONE;
  logic       BUSY;
  logic [3:0] CNT_OUT;

  logic [1:0] REQ1, X1, GNT1, DONE1;
  logic       BUSY1;
  logic [3:0] CNT_OUT1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  exp_t q0[$];
  exp_t q1[$];

  count_share_arbiter #(.CNT_W(4), .TARGET(15)) dut (
    .CLK(CLK), .CLEAR(CLEAR), .REQ(REQ), .X(X),
    .GNT(GNT), .DONE(DONE), .BUSY(BUSY), .CNT_OUT(CNT_OUT)
  );

  count_share_arbiter #(.CNT_W(4), .TARGET(1)) dut1 (
    .CLK(CLK), .CLEAR(CLEAR), .REQ(REQ1), .X(X1),
    .GNT(GNT1), .DONE(DONE1), .BUSY(BUSY1), .CNT_OUT(CNT_OUT1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic push0(input logic [1:0] d, input logic [3:0] c);
    exp_t e;
    e.done = d;
    e.cnt  = c;
    q0.push_back(e);
  endtask

  task automatic do_reset();
    CLEAR = 1'b1;
    REQ = '0; X = '0; REQ1 = '0; X1 = '0;
    #3;
    @(negedge CLK);
    CLEAR = 1'b0;
  endtask

  // DONE monitors: every DONE pulse must match the head of its expected queue.
  always @(negedge CLK) begin
    if (DONE !== 2'b00) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got %0h expected none at %0t", DONE, $time);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("done", 32'(DONE), 32'(e.done));
        chk("done_cnt", 32'(CNT_OUT), 32'(e.cnt));
      end
    end
  end

  always @(negedge CLK) begin
    if (DONE1 !== 2'b00) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done1: got %0h expected none at %0t", DONE1, $time);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("done1", 32'(DONE1), 32'(e.done));
        chk("done1_cnt", 32'(CNT_OUT1), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    CLEAR = 1'b1;
    REQ = '0; X = '0; REQ1 = '0; X1 = '0;
    #2;
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_done", 32'(DONE), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_cnt", 32'(CNT_OUT), 32'h0);
    @(negedge CLK);
    CLEAR = 1'b0;

    // Single requester, X held
    REQ = 2'b01; X = 2'b01;
    push0(2'b01, 4'd15);
    tick();
    chk("s1_gnt", 32'(GNT), 32'h1);
    chk("s1_busy", 32'(BUSY), 32'h1);
    tick();
    chk("s1_clr", 32'(CNT_OUT), 32'h0);
    ticks(14);
    chk("s1_cnt14", 32'(CNT_OUT), 32'd14);
    chk("s1_nodone", 32'(DONE), 32'h0);
    tick();
    chk("s1_fin_done", 32'(DONE), 32'h1);
    chk("s1_fin_cnt", 32'(CNT_OUT), 32'd15);
    REQ = '0; X = '0;
    tick();
    chk("s1_idle_gnt", 32'(GNT), 32'h0);
    chk("s1_idle_busy", 32'(BUSY), 32'h0);
    chk("s1_hold", 32'(CNT_OUT), 32'd15);

    // Both requesting: alternation 0,1,0
    do_reset();
    REQ = 2'b11; X = 2'b11;
    push0(2'b01, 4'd15);
    push0(2'b10, 4'd15);
    push0(2'b01, 4'd15);
    tick();
    chk("s2_gnt_a", 32'(GNT), 32'h1);
    ticks(17);
    chk("s2_idle_a", 32'(GNT), 32'h0);
    tick();
    chk("s2_gnt_b", 32'(GNT), 32'h2);
    ticks(16);
    chk("s2_fin_b", 32'(DONE), 32'h2);
    tick();
    chk("s2_idle_b", 32'(GNT), 32'h0);
    tick();
    chk("s2_gnt_c", 32'(GNT), 32'h1);
    ticks(16);
    chk("s2_fin_c", 32'(DONE), 32'h1);
    REQ = '0; X = '0;
    tick();
    chk("s2_end", 32'(BUSY), 32'h0);

    // X[0] alternating, X[1] always high; X in CLR ignored
    do_reset();
    REQ = 2'b01; X = 2'b10;
    push0(2'b01, 4'd15);
    tick();
    chk("s3_gnt", 32'(GNT), 32'h1);
    X = 2'b11;
    tick();
    chk("s3_clr_ignore_x", 32'(CNT_OUT), 32'h0);
    for (int unsigned k = 2; k <= 30; k++) begin
      X = {1'b1, ((k % 2) == 0)};
      tick();
      if (k < 30) chk("s3_cnt", 32'(CNT_OUT), k / 2);
    end
    chk("s3_done", 32'(DONE), 32'h1);
    REQ = '0; X = '0;
    tick();
    chk("s3_end", 32'(BUSY), 32'h0);

    // Abort at CNT_OUT=7, then fairness
    do_reset();
    REQ = 2'b01; X = 2'b01;
    ticks(9);
    chk("s4_cnt7", 32'(CNT_OUT), 32'd7);
    REQ = 2'b00;
    tick();
    chk("s4_abort_gnt", 32'(GNT), 32'h0);
    chk("s4_abort_busy", 32'(BUSY), 32'h0);
    chk("s4_abort_hold", 32'(CNT_OUT), 32'd7);
    REQ = 2'b11; X = 2'b00;
    tick();
    chk("s4_fair_gnt", 32'(GNT), 32'h2);
    tick();
    chk("s4_fair_clr", 32'(CNT_OUT), 32'h0);
    REQ = '0;
    ticks(2);
    chk("s4_end", 32'(BUSY), 32'h0);

    // Abort beats a simultaneous final increment
    do_reset();
    REQ = 2'b01; X = 2'b01;
    ticks(16);
    chk("s4b_cnt14", 32'(CNT_OUT), 32'd14);
    REQ = 2'b00;
    tick();
    chk("s4b_abort_cnt", 32'(CNT_OUT), 32'd14);
    chk("s4b_abort_busy", 32'(BUSY), 32'h0);
    X = '0;

    // Asynchronous reset mid-count
    do_reset();
    REQ = 2'b01; X = 2'b01;
    ticks(11);
    chk("s5_cnt9", 32'(CNT_OUT), 32'd9);
    #2;
    CLEAR = 1'b1;
    #1;
    chk("s5_async_gnt", 32'(GNT), 32'h0);
    chk("s5_async_cnt", 32'(CNT_OUT), 32'h0);
    chk("s5_async_busy", 32'(BUSY), 32'h0);
    @(negedge CLK);
    CLEAR = 1'b0;
    REQ = 2'b11; X = 2'b00;
    tick();
    chk("s5_prio0", 32'(GNT), 32'h1);
    REQ = '0;
    ticks(2);
    chk("s5_end", 32'(BUSY), 32'h0);

    // TARGET=1 instance
    REQ1 = 2'b10; X1 = 2'b10;
    begin
      exp_t e;
      e.done = 2'b10;
      e.cnt  = 4'd1;
      q1.push_back(e);
    end
    tick();
    chk("s6_gnt", 32'(GNT1), 32'h2);
    tick();
    chk("s6_clr", 32'(CNT_OUT1), 32'h0);
    tick();
    chk("s6_done", 32'(DONE1), 32'h2);
    chk("s6_cnt", 32'(CNT_OUT1), 32'd1);
    REQ1 = '0; X1 = '0;
    tick();
    chk("s6_idle", 32'(GNT1), 32'h0);

    ticks(2);
    chk("pending0", q0.size(), 32'd0);
    chk("pending1", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
